// File: rtl/mem_row_reader.sv
// Row-at-a-time read sequencer for the banked scratchpad: walks a 2-D tile,
// issues one memory read per row and streams the captured rows through a small FIFO.
module mem_row_reader #(
  parameter int NUM_RAMS   = 16,
  parameter int D_WID      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [31:0]               row_stride,
  input  logic [15:0]               num_rows,
  input  logic [4:0]                row_bytes,
  input  logic                      system_bus_en,
  output logic                      interface_en,
  output logic                      interface_rdwr,
  output logic [4:0]                interface_control,
  output logic [31:0]               interface_addr,
  input  logic [NUM_RAMS*D_WID-1:0] bank_dout,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [NUM_RAMS*D_WID-1:0] row_data,
  output logic                      row_last,
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_W = NUM_RAMS * D_WID;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       cur_addr, stride_q;
  logic [15:0]       num_rows_q, issued_rows;
  logic [4:0]        bytes_q, bytes_clamped;
  logic              inflight, inflight_last;
  logic              issue, last_issue, push, pop;
  logic [ROW_W-1:0]  masked;

  logic [ROW_W-1:0]  fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign bytes_clamped = (row_bytes == 5'd0 || int'(row_bytes) > NUM_RAMS)
                         ? 5'(NUM_RAMS) : row_bytes;

  // Counting the read in flight reserves its FIFO slot, so a push never finds the FIFO full.
  assign issue      = (state == RUN) && !system_bus_en &&
                      ((int'(count) + int'(inflight)) < FIFO_DEPTH);
  assign last_issue = (issued_rows == num_rows_q - 16'd1);
  assign push       = inflight;
  assign pop        = row_valid && row_ready;

  assign interface_en      = issue;
  assign interface_rdwr    = 1'b0;
  assign interface_control = bytes_q;
  assign interface_addr    = cur_addr;

  assign row_valid = (count != '0);
  assign row_data  = row_valid ? fifo_data[rd_ptr] : '0;
  assign row_last  = row_valid ? fifo_last[rd_ptr] : 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_RAMS; i++) begin
      if (i < int'(bytes_q)) masked[i*D_WID +: D_WID] = bank_dout[i*D_WID +: D_WID];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_rows == 16'd0) ? DONE : RUN;
      RUN:     if (issue && last_issue) state_nxt = DRAIN;
      // Leave DRAIN as the final row is accepted so done lands on the following cycle.
      DRAIN:   if (!inflight && count == CNT_W'(pop)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      stride_q      <= '0;
      num_rows_q    <= '0;
      bytes_q       <= '0;
      issued_rows   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && last_issue;
      if (state == IDLE && start) begin
        cur_addr    <= base_addr;
        stride_q    <= row_stride;
        num_rows_q  <= num_rows;
        bytes_q     <= bytes_clamped;
        issued_rows <= '0;
      end else if (issue) begin
        cur_addr    <= cur_addr + stride_q;
        issued_rows <= issued_rows + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; count gates the outputs, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= masked;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

endmodule
